// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the NES sprite (OAM) DMA engine.
package nes_dma_pkg;

  typedef enum logic [1:0] {IDLE, ALIGN, READ, WRITE} dma_state_t;

  localparam logic [15:0] OAM_DMA_REG = 16'h4014;
  localparam int          OAM_XFER_BYTES = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: a CPU write to $4014 stalls the CPU and copies one WRAM page into OAM.
// Optional OAM_DMA_ODD_ALIGN_EN adds a second align cycle when triggered on an odd clock.
module oam_dma_ctrl
  import nes_dma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_REG,
  parameter int          OAM_BYTES    = OAM_XFER_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_r_nw,
  input  logic [7:0]  wram_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_r_nw,
  output logic        cpu_rdy,
  output logic        oam_dma,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

  dma_state_t state_q;
  logic [7:0] page_q, idx_q;
  logic       cpu_rdy_q, oam_dma_q, oam_we_q;
  logic [7:0] oam_addr_q, oam_data_q;
  logic       trig;

  assign trig = (cpu_addr == DMA_REG_ADDR) && !cpu_r_nw;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic parity_q, extra_q;

  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= ~parity_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      cpu_rdy_q  <= 1'b1;
      oam_dma_q  <= 1'b0;
      oam_we_q   <= 1'b0;
      oam_addr_q <= 8'h00;
      oam_data_q <= 8'h00;
`ifdef OAM_DMA_ODD_ALIGN_EN
      extra_q    <= 1'b0;
`endif
    end else begin
      oam_we_q <= 1'b0;
      case (state_q)
        IDLE: if (trig) begin
          page_q    <= cpu_data;
          idx_q     <= 8'h00;
          cpu_rdy_q <= 1'b0;
          oam_dma_q <= 1'b1;
          state_q   <= ALIGN;
`ifdef OAM_DMA_ODD_ALIGN_EN
          extra_q   <= parity_q;
`endif
        end
        ALIGN: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          if (extra_q) extra_q <= 1'b0;
          else         state_q <= READ;
`else
          state_q <= READ;
`endif
        end
        READ: state_q <= WRITE;
        WRITE: begin
          // WRAM data for the READ-cycle address is valid now.
          oam_addr_q <= idx_q;
          oam_data_q <= wram_rdata;
          oam_we_q   <= 1'b1;
          idx_q      <= idx_q + 8'h01;
          if (idx_q == LAST_IDX) begin
            state_q   <= IDLE;
            cpu_rdy_q <= 1'b1;
            oam_dma_q <= 1'b0;
          end else begin
            state_q <= READ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address mux is the only combinational path through the block.
  assign mem_addr = (state_q == IDLE) ? cpu_addr : {page_q, idx_q};
  assign mem_r_nw = (state_q == IDLE) ? cpu_r_nw : 1'b1;

  assign cpu_rdy  = cpu_rdy_q;
  assign oam_dma  = oam_dma_q;
  assign oam_addr = oam_addr_q;
  assign oam_data = oam_data_q;
  assign oam_we   = oam_we_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: vector table for the idle path, scoreboard for OAM writes.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_r_nw;
  logic [7:0]  wram_rdata = 8'h00;
  logic [15:0] mem_addr;
  logic        mem_r_nw;
  logic        cpu_rdy, oam_dma, oam_we;
  logic [7:0]  oam_addr, oam_data;

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_r_nw(cpu_r_nw), .wram_rdata(wram_rdata), .mem_addr(mem_addr),
    .mem_r_nw(mem_r_nw), .cpu_rdy(cpu_rdy), .oam_dma(oam_dma),
    .oam_addr(oam_addr), .oam_data(oam_data), .oam_we(oam_we)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // WRAM image: page 2 holds i^A5; other pages mix in the page byte so a page carry shows up.
  function automatic logic [7:0] wram_val(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge clk) wram_rdata <= wram_val(mem_addr);

  logic par_q = 1'b0;
  always @(posedge clk) par_q <= reset ? 1'b0 : ~par_q;

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } oam_wr_t;
  oam_wr_t sb_q[$];

  logic        ff_mon = 1'b0;
  int          ff_bad = 0;
  logic [15:0] ff_max = 16'h0000;

  always @(negedge clk) begin
    if (oam_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("oam_we_unexpected", 32'(oam_addr), 32'hFFFF_FFFF);
      end else begin
        oam_wr_t e;
        e = sb_q.pop_front();
        chk("oam_addr", 32'(oam_addr), 32'(e.addr));
        chk("oam_data", 32'(oam_data), 32'(e.data));
      end
    end
    if (ff_mon && oam_dma === 1'b1) begin
      if (mem_addr[15:8] != 8'hFF) ff_bad++;
      if (mem_addr > ff_max) ff_max = mem_addr;
    end
  end

  task automatic push_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) sb_q.push_back({8'(i), wram_val({page, 8'(i)})});
  endtask

  // Called at a negedge; drives the $4014 write and measures the cpu_rdy low window.
  task automatic run_dma(input string name, input logic [7:0] page, input logic hold,
                         input logic [7:0] hold_data);
    int stall, dma_bad, exp_stall;
    push_page(page);
    exp_stall = 513;
`ifdef OAM_DMA_ODD_ALIGN_EN
    if (par_q) exp_stall = 514;
`endif
    cpu_addr = 16'h4014; cpu_data = page; cpu_r_nw = 1'b0;
    @(negedge clk);
    if (!hold) begin cpu_r_nw = 1'b1; cpu_addr = 16'h0123; end
    else cpu_data = hold_data;
    stall = 0; dma_bad = 0;
    while (cpu_rdy === 1'b0 && stall < 2000) begin
      if (oam_dma !== 1'b1) dma_bad++;
      stall++;
      @(negedge clk);
    end
    cpu_r_nw = 1'b1; cpu_addr = 16'h0123;
    chk({name, "_stall"}, 32'(stall), 32'(exp_stall));
    chk({name, "_dma_flag"}, 32'(dma_bad), 32'd0);
    repeat (3) @(negedge clk);
    chk({name, "_oam_dma_off"}, 32'(oam_dma), 32'd0);
    chk({name, "_all_writes"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  typedef struct {
    logic [15:0] addr; logic [7:0] data; logic r_nw;
    logic [15:0] exp_mem_addr; logic exp_r_nw; logic exp_rdy;
  } vec_t;
  vec_t vecs[6];

  initial begin
    bit found;
    vecs[0] = '{16'h4014, 8'h55, 1'b1, 16'h4014, 1'b1, 1'b1};
    vecs[1] = '{16'h4015, 8'h02, 1'b0, 16'h4015, 1'b0, 1'b1};
    vecs[2] = '{16'h4013, 8'h02, 1'b0, 16'h4013, 1'b0, 1'b1};
    vecs[3] = '{16'h0200, 8'h00, 1'b1, 16'h0200, 1'b1, 1'b1};
    vecs[4] = '{16'hC014, 8'hAA, 1'b0, 16'hC014, 1'b0, 1'b1};
    vecs[5] = '{16'h4014, 8'h07, 1'b1, 16'h4014, 1'b1, 1'b1};

    reset = 1'b1; cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_r_nw = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_oam_dma", 32'(oam_dma), 32'd0);
    chk("rst_oam_we", 32'(oam_we), 32'd0);
    chk("rst_oam_addr", 32'(oam_addr), 32'd0);
    chk("rst_oam_data", 32'(oam_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Idle pass-through, including a read of $4014 that must not trigger.
    foreach (vecs[i]) begin
      cpu_addr = vecs[i].addr; cpu_data = vecs[i].data; cpu_r_nw = vecs[i].r_nw;
      #1;
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_mem_addr));
      chk($sformatf("vec%0d_mem_r_nw", i), 32'(mem_r_nw), 32'(vecs[i].exp_r_nw));
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_rdy", i), 32'(cpu_rdy), 32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_oam_dma", i), 32'(oam_dma), 32'd0);
    end
    cpu_addr = 16'h0123; cpu_r_nw = 1'b1;
    @(negedge clk);

    run_dma("page02", 8'h02, 1'b0, 8'h00);
    @(negedge clk);
    run_dma("held_trig", 8'h03, 1'b1, 8'h05);
    @(negedge clk);

    ff_mon = 1'b1;
    run_dma("pageFF", 8'hFF, 1'b0, 8'h00);
    ff_mon = 1'b0;
    chk("pageFF_no_carry", 32'(ff_bad), 32'd0);
    chk("pageFF_last_addr", 32'(ff_max), 32'hFFFF);

    // Reset right after OAM byte 100 is written.
    push_page(8'h04);
    cpu_addr = 16'h4014; cpu_data = 8'h04; cpu_r_nw = 1'b0;
    @(negedge clk);
    cpu_addr = 16'h0123; cpu_r_nw = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (oam_we === 1'b1 && oam_addr == 8'd100) found = 1'b1;
    end
    chk("midrst_reached_100", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cpu_rdy", 32'(cpu_rdy), 32'd1);
    chk("midrst_oam_dma", 32'(oam_dma), 32'd0);
    chk("midrst_oam_we", 32'(oam_we), 32'd0);
    sb_q.delete();
    reset = 1'b0;
    @(negedge clk);
    run_dma("after_rst", 8'h04, 1'b0, 8'h00);

    // Trigger and reset on the same edge: reset wins.
    reset = 1'b1; cpu_addr = 16'h4014; cpu_data = 8'h02; cpu_r_nw = 1'b0;
    @(negedge clk);
    chk("rst_vs_trig_rdy", 32'(cpu_rdy), 32'd1);
    chk("rst_vs_trig_dma", 32'(oam_dma), 32'd0);
    reset = 1'b0; cpu_addr = 16'h0123; cpu_r_nw = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_vs_trig_idle", 32'(cpu_rdy), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
